dbus_arbiter: RTL
=================

Name: dbus_arbiter

Overview:
- Shares the single core data-memory port (req/gnt/rvalid protocol driven by the LSU) between two requesters.
  - Port 0: LSU.
  - Port 1: a secondary master such as debug or DMA.
- Round-robin arbitration with request lock while a request waits for grant.
- An in-order outstanding-ID FIFO routes each rvalid and rdata back to the requester that issued it.
- Sits between ex_stage's data interface and the memory/bus.

Parameters:
- MAX_OUTST, 2, maximum accepted-but-unanswered transactions (1..4).
- ID_W, 1, width of a requester ID (fixed to 1 for two ports).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  2  per-requester request
- m_gnt_o  out  2  per-requester grant
- m_rvalid_o  out  2  per-requester response valid
- m_addr_i  in  2x32  per-requester address
- m_we_i  in  2  per-requester write enable
- m_be_i  in  2x4  per-requester byte enables
- m_wdata_i  in  2x32  per-requester write data
- m_rdata_o  out  32  response data, broadcast to both requesters
- data_req_o  out  1  downstream request
- data_gnt_i  in  1  downstream grant
- data_rvalid_i  in  1  downstream response valid
- data_addr_o  out  32  downstream address
- data_we_o  out  1  downstream write enable
- data_be_o  out  4  downstream byte enables
- data_wdata_o  out  32  downstream write data
- data_rdata_i  in  32  downstream read data
- resp_err_o  out  1  sticky: rvalid arrived with no outstanding entry

Behaviour:
- Reset (async, rst_ni=0):
  - FSM=ARB, rr_ptr=0, FIFO empty, lock_id=0, resp_err_o=0.
  - All outputs 0 while in reset, since m_req_i has no effect then.
- FSM states:
  - ARB: selection is combinational.
    - If only one m_req_i bit is set, that requester wins.
    - If both are set, the winner is rr_ptr.
  - LOCKED: the winner is lock_id regardless of m_req_i.
- Transitions:
  - ARB->LOCKED when data_req_o=1 and data_gnt_i=0; lock_id latches the current winner.
  - LOCKED->ARB when data_gnt_i=1.
  - This keeps addr/we/be/wdata stable until grant. A requester must hold req and its fields until granted.
- Output mux:
  - data_req_o = winner exists AND fifo not full.
  - data_addr_o, data_we_o, data_be_o, data_wdata_o = winner's fields, or 0 when there is no winner.
- Grant: m_gnt_o[winner] = data_gnt_i & data_req_o; the other bit is 0. Zero-latency combinational pass-through.
- On an accepted transfer (data_req_o & data_gnt_i):
  - Push the winner ID into the FIFO.
  - rr_ptr <= ~winner, so the loser gets priority next.
- Response path:
  - On data_rvalid_i with the FIFO non-empty: m_rvalid_o[head] = 1 in the same cycle, then pop.
  - m_rdata_o = data_rdata_i at all times.
- Full FIFO (count==MAX_OUTST):
  - data_req_o is forced to 0, even when a pop happens in the same cycle. No same-cycle bypass.
  - The FSM stays in its current state.
- Push and pop in the same cycle (not full): count is unchanged; pointers advance modulo MAX_OUTST.
- data_rvalid_i with the FIFO empty: no m_rvalid_o, no pop, resp_err_o <= 1. It clears only on reset.
- Reset mid-transaction: the FIFO and lock are discarded; upstream must be reset together with the block.
- The rvalid of an earlier transfer may coincide with a new grant; both must be processed that cycle.

Decomposition:
- milano_pkg gains:
  - dbus_id_t, a logic [ID_W-1:0] typedef.
  - DBUS_MAX_OUTST, localparam default 2.
  - dbus_arb_state_e, enum {ARB, LOCKED}.
- One sub-module, dbus_id_fifo:
  - Parameterised depth and width, synchronous push/pop, async active-low reset.
  - Outputs full, empty and head.
- The arbiter instantiates it and contains the FSM, rr_ptr, mux and error flag.

Test Plan:
1. Single requester, write:
   - Stimulus: m_req_i=01, addr 0x100, wdata 0xDEADBEEF, be 0xF, we=1, gnt immediate.
   - Required: data_addr_o=0x100 that cycle, m_gnt_o=01; rvalid next cycle gives m_rvalid_o=01.
2. Contention fairness:
   - Stimulus: m_req_i=11 for 4 back-to-back granted cycles after reset.
   - Required: grants in order port0, port1, port0, port1.
3. Grant stall lock:
   - Stimulus: port1 requests, gnt=0 for 3 cycles; port0 raises req in cycle 2; gnt=1 in cycle 4.
   - Required: data_addr_o holds port1's address throughout and m_gnt_o=10 in cycle 4; port0 is granted after.
4. Outstanding limit and routing:
   - Stimulus: MAX_OUTST=2; grant port0 then port1 with no rvalid; port0 requests again.
   - Required: data_req_o=0. Then two rvalids with rdata 0x11, 0x22 give m_rvalid_o=01 then 10. The third request is issued only after the first pop.
5. Spurious response:
   - Stimulus: data_rvalid_i=1 with the FIFO empty.
   - Required: m_rvalid_o=00, resp_err_o=1 from the next cycle and sticky; an async reset pulse clears it.
6. Reset mid-lock:
   - Stimulus: drop rst_ni while in LOCKED with 1 outstanding entry.
   - Required: all outputs 0 immediately and FSM=ARB; after release, a new request goes out with rr_ptr=0 priority.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core. This slice holds the data-bus
// arbiter types: requester ID, default outstanding depth and arbiter FSM states.
package milano_pkg;

  localparam int DBUS_ID_W      = 1;
  localparam int DBUS_MAX_OUTST = 2;

  typedef logic [DBUS_ID_W-1:0] dbus_id_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } dbus_arb_state_e;

endpackage

// File: rtl/dbus_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered data-bus transfers.
// Synchronous push/pop; a push while full or a pop while empty is ignored.
module dbus_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is left unreset; count/empty guard every read, so only the
  // control state needs a reset value and the array stays plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-port round-robin arbiter for the core data-memory port, with grant-stall
// locking and an in-order ID FIFO that steers responses back to their issuer.
module dbus_arbiter
  import milano_pkg::*;
#(
  parameter int MAX_OUTST = DBUS_MAX_OUTST,
  parameter int ID_W      = DBUS_ID_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      m_req_i,
  output logic [1:0]      m_gnt_o,
  output logic [1:0]      m_rvalid_o,
  input  logic [1:0][31:0] m_addr_i,
  input  logic [1:0]      m_we_i,
  input  logic [1:0][3:0] m_be_i,
  input  logic [1:0][31:0] m_wdata_i,
  output logic [31:0]     m_rdata_o,
  output logic            data_req_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  output logic [31:0]     data_addr_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [31:0]     data_wdata_o,
  input  logic [31:0]     data_rdata_i,
  output logic            resp_err_o
);

  dbus_arb_state_e state, state_next;
  dbus_id_t        rr_ptr;
  dbus_id_t        lock_id;
  dbus_id_t        winner;
  logic            winner_valid;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            accept;
  logic            resp_fire;

  // Everything is gated by rst_ni so the block is silent while held in reset.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    winner_valid = 1'b0;
    winner       = '0;
    if (rst_ni) begin
      if (state == LOCKED) begin
        winner_valid = 1'b1;
        winner       = lock_id;
      end else begin
        unique case (m_req_i)
          2'b01:   begin winner_valid = 1'b1; winner = 1'b0;   end
          2'b10:   begin winner_valid = 1'b1; winner = 1'b1;   end
          2'b11:   begin winner_valid = 1'b1; winner = rr_ptr; end
          default: ;
        endcase
      end
    end
  end

  assign data_req_o   = winner_valid & ~fifo_full;
  assign accept       = data_req_o & data_gnt_i;
  assign data_addr_o  = winner_valid ? m_addr_i[winner]  : '0;
  assign data_we_o    = winner_valid ? m_we_i[winner]    : 1'b0;
  assign data_be_o    = winner_valid ? m_be_i[winner]    : '0;
  assign data_wdata_o = winner_valid ? m_wdata_i[winner] : '0;
  assign m_gnt_o      = accept ? (2'b01 << winner) : 2'b00;

  assign resp_fire  = rst_ni & data_rvalid_i & ~fifo_empty;
  assign m_rvalid_o = resp_fire ? (2'b01 << fifo_head) : 2'b00;
  assign m_rdata_o  = rst_ni ? data_rdata_i : '0;

  // A full FIFO drops data_req_o, which also freezes the FSM in place.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB:     if (data_req_o && !data_gnt_i) state_next = LOCKED;
      LOCKED:  if (accept)                    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ARB;
      rr_ptr     <= '0;
      lock_id    <= '0;
      resp_err_o <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ARB && data_req_o && !data_gnt_i) lock_id <= winner;
      if (accept) rr_ptr <= ~winner;
      if (data_rvalid_i && fifo_empty) resp_err_o <= 1'b1;
    end
  end

  dbus_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept),
    .push_data (winner),
    .pop       (resp_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule
